// File: rtl/serial_frame_receiver.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits, optional
// parity bit, stop bit. Good words are offered on a valid/ready port.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   sin           - serial line (idles high), sampled only when sin_valid=1
//   sin_valid     - bit strobe
//   out_ready     - consumer accepts data_out this cycle
//   err_clr       - clears the sticky overrun flag
//   data_out      - received word, stable while out_valid=1
//   out_valid     - data_out holds an unconsumed word
//   parity_err    - one-cycle pulse, parity mismatch (word discarded)
//   frame_err     - one-cycle pulse, stop bit was 0 (word discarded)
//   overrun       - sticky, good word dropped because holding register full
//   busy          - receiver is inside a frame
module serial_frame_receiver #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned MSB_FIRST  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             out_ready,
   input  logic             err_clr,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic               rx_par_q, rx_par_d;
   logic [WIDTH-1:0]   data_d;
   logic               valid_d;
   logic               perr_d;
   logic               ferr_d;
   logic               ovr_d;
   logic               good_c;
   logic               exp_par_c;

   assign exp_par_c = (^shreg_q) ^ 1'(PARITY_ODD);

   // Next-state, datapath and output-update logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      rx_par_d = rx_par_q;
      data_d   = data_out;
      valid_d  = out_valid;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      ovr_d    = overrun & ~err_clr;
      good_c   = 1'b0;

      if (out_valid && out_ready) begin
         valid_d = 1'b0;
      end

      if (sin_valid) begin
         case (state_q)
            IDLE: begin
               if (!sin) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end
            end
            DATA: begin
               if (MSB_FIRST != 0) begin
                  shreg_d = {shreg_q[WIDTH-2:0], sin};
               end else begin
                  shreg_d = {sin, shreg_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
            PARITY: begin
               rx_par_d = sin;
               state_d  = STOP;
            end
            STOP: begin
               // Returns to IDLE; this strobe is never treated as a start bit
               state_d = IDLE;
               if (!sin) begin
                  ferr_d = 1'b1;
               end else if ((PARITY_EN != 0) && (rx_par_q != exp_par_c)) begin
                  perr_d = 1'b1;
               end else begin
                  good_c = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Load a good word if the holding register is free or being drained now
      if (good_c) begin
         if (!out_valid || out_ready) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shreg_q    <= '0;
         rx_par_q   <= 1'b0;
         data_out   <= '0;
         out_valid  <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         rx_par_q   <= rx_par_d;
         data_out   <= data_d;
         out_valid  <= valid_d;
         parity_err <= perr_d;
         frame_err  <= ferr_d;
         overrun    <= ovr_d;
         busy       <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (WIDTH=8, even parity, LSB first).
module tb_serial_frame_receiver;

   logic       clk = 1'b0;
   logic       rst;
   logic       sin;
   logic       sin_valid;
   logic       out_ready;
   logic       err_clr;
   logic [7:0] data_out;
   logic       out_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int tests = 0;
   int fails = 0;

   serial_frame_receiver #(
      .WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .MSB_FIRST(0)
   ) dut (
      .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
      .out_ready(out_ready), .err_clr(err_clr), .data_out(data_out),
      .out_valid(out_valid), .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       par_flip;
      logic       stop;
      logic       ready;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic       exp_perr;
      logic       exp_ferr;
      logic       exp_ovr;
      logic       exp_valid_after;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One strobed bit; returns 1 time unit after the sampling edge
   task automatic strobe(input logic b, input logic rdy);
      @(negedge clk);
      sin       = b;
      sin_valid = 1'b1;
      out_ready = rdy;
      @(posedge clk);
      #1;
      sin_valid = 1'b0;
   endtask

   // One cycle without a strobe; sin toggled to show it is ignored
   task automatic idle(input logic rdy, input logic clr);
      @(negedge clk);
      sin_valid = 1'b0;
      sin       = ~sin;
      out_ready = rdy;
      err_clr   = clr;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] d, input int nbits, input logic rdy, input int gap);
      strobe(1'b0, rdy);
      for (int i = 0; i < nbits; i++) begin
         for (int g = 0; g < gap; g++) idle(rdy, 1'b0);
         strobe(d[i], rdy);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                             input logic rdy, input logic rdy_stop, input int gap);
      send_bits(d, 8, rdy, gap);
      for (int g = 0; g < gap; g++) idle(rdy, 1'b0);
      strobe((^d) ^ flip, rdy);
      for (int g = 0; g < gap; g++) idle(rdy, 1'b0);
      strobe(stop, rdy_stop);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{8'hC3, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

      rst = 1'b1; sin = 1'b1; sin_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_data", 16'(data_out), 16'h0);
      check("rst_valid", 16'(out_valid), 16'h0);
      check("rst_perr", 16'(parity_err), 16'h0);
      check("rst_ferr", 16'(frame_err), 16'h0);
      check("rst_ovr", 16'(overrun), 16'h0);
      check("rst_busy", 16'(busy), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         strobe(1'b1, 1'b0);
         check("idle_busy", 16'(busy), 16'h0);
         check("idle_valid", 16'(out_valid), 16'h0);
      end

      // Table-driven frames: checked right after the stop edge, then one idle cycle later
      for (int i = 0; i < 7; i++) begin
         send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop, vecs[i].ready, vecs[i].ready, 0);
         check($sformatf("v%0d_data", i), 16'(data_out), 16'(vecs[i].exp_data));
         check($sformatf("v%0d_valid", i), 16'(out_valid), 16'(vecs[i].exp_valid));
         check($sformatf("v%0d_perr", i), 16'(parity_err), 16'(vecs[i].exp_perr));
         check($sformatf("v%0d_ferr", i), 16'(frame_err), 16'(vecs[i].exp_ferr));
         check($sformatf("v%0d_ovr", i), 16'(overrun), 16'(vecs[i].exp_ovr));
         check($sformatf("v%0d_busy", i), 16'(busy), 16'h0);
         idle(vecs[i].ready, 1'b0);
         check($sformatf("v%0d_valid_after", i), 16'(out_valid), 16'(vecs[i].exp_valid_after));
         check($sformatf("v%0d_pulse_gone", i), 16'({parity_err, frame_err}), 16'h0);
         check($sformatf("v%0d_data_after", i), 16'(data_out), 16'(vecs[i].exp_data));
      end

      // Overrun clear, then drain
      idle(1'b0, 1'b1);
      check("clr_ovr", 16'(overrun), 16'h0);
      check("clr_valid", 16'(out_valid), 16'h1);
      check("clr_data", 16'(data_out), 16'h3C);
      idle(1'b1, 1'b0);
      check("drain_valid", 16'(out_valid), 16'h0);

      // Accept of 0x11 on the same edge that 0x22 lands
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      check("hold11_data", 16'(data_out), 16'h11);
      check("hold11_valid", 16'(out_valid), 16'h1);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 0);
      check("swap_data", 16'(data_out), 16'h22);
      check("swap_valid", 16'(out_valid), 16'h1);
      check("swap_ovr", 16'(overrun), 16'h0);
      idle(1'b1, 1'b0);
      check("swap_drain", 16'(out_valid), 16'h0);

      // Strobe gaps of 3 cycles between every bit
      send_bits(8'h5A, 3, 1'b1, 3);
      idle(1'b1, 1'b0);
      check("gap_busy", 16'(busy), 16'h1);
      check("gap_valid", 16'(out_valid), 16'h0);
      for (int g = 0; g < 2; g++) idle(1'b1, 1'b0);
      for (int i = 3; i < 8; i++) begin
         strobe(8'h5A >> i, 1'b1);
         for (int g = 0; g < 3; g++) idle(1'b1, 1'b0);
      end
      strobe(1'b0, 1'b1);
      for (int g = 0; g < 3; g++) idle(1'b1, 1'b0);
      strobe(1'b1, 1'b0);
      check("gap_data", 16'(data_out), 16'h5A);
      check("gap_rx_valid", 16'(out_valid), 16'h1);
      check("gap_errs", 16'({parity_err, frame_err}), 16'h0);
      idle(1'b1, 1'b0);

      // Reset after 4 data bits, then a full frame
      send_bits(8'hFF, 4, 1'b1, 0);
      check("mid_busy", 16'(busy), 16'h1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_busy", 16'(busy), 16'h0);
      check("mid_rst_data", 16'(data_out), 16'h0);
      check("mid_rst_valid", 16'(out_valid), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      send_frame(8'h96, 1'b0, 1'b1, 1'b1, 1'b1, 0);
      check("post_rst_data", 16'(data_out), 16'h96);
      check("post_rst_valid", 16'(out_valid), 16'h1);
      check("post_rst_errs", 16'({parity_err, frame_err, overrun}), 16'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
